// File: rtl/icache_ifill_unit.sv
// Instruction-cache refill engine: takes one miss, issues a fill request to L2,
// gathers out-of-order response beats into a full line and strobes it out for one cycle.
module icache_ifill_unit #(
    parameter int PADDR_SIZE = 27,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int N_WAY      = 4,
    localparam int NBEATS    = LINE_WIDTH / BEAT_WIDTH,
    localparam int WAY_W     = (N_WAY > 1) ? $clog2(N_WAY) : 1,
    localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [PADDR_SIZE-1:0] miss_paddr_i,
    input  logic [WAY_W-1:0]      miss_way_i,
    input  logic                  kill_i,
    output logic                  ifill_req_valid_o,
    output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
    output logic [WAY_W-1:0]      ifill_req_way_o,
    input  logic                  ifill_ack_i,
    input  logic                  ifill_resp_valid_i,
    input  logic [BEAT_WIDTH-1:0] ifill_resp_data_i,
    input  logic [BEAT_W-1:0]     ifill_resp_beat_i,
    output logic                  line_valid_o,
    output logic [LINE_WIDTH-1:0] line_data_o,
    output logic [PADDR_SIZE-1:0] line_paddr_o,
    output logic [WAY_W-1:0]      line_way_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        DRAIN,
        WRITE
    } state_t;

    state_t                state;
    logic [NBEATS-1:0]     mask;
    logic [NBEATS-1:0]     beat_hit;
    logic [NBEATS-1:0]     mask_next;
    logic                  mask_full;
    logic [BEAT_W-1:0]     slot;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic [WAY_W-1:0]      way_q;
    logic [LINE_WIDTH-1:0] line_buf;

    // With a single beat per line the index carries no information; pin it to slot 0.
    always_comb begin
        slot           = (NBEATS == 1) ? '0 : ifill_resp_beat_i;
        beat_hit       = '0;
        beat_hit[slot] = ifill_resp_valid_i;
        mask_next      = mask | beat_hit;
        mask_full      = &mask_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            mask              <= '0;
            paddr_q           <= '0;
            way_q             <= '0;
            line_buf          <= '0;
            miss_ready_o      <= 1'b1;
            ifill_req_valid_o <= 1'b0;
            line_valid_o      <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid_i) begin
                        paddr_q           <= miss_paddr_i;
                        way_q             <= miss_way_i;
                        mask              <= '0;
                        state             <= REQ;
                        miss_ready_o      <= 1'b0;
                        ifill_req_valid_o <= 1'b1;
                        busy_o            <= 1'b1;
                    end
                end
                REQ: begin
                    if (ifill_ack_i) begin
                        ifill_req_valid_o <= 1'b0;
                        state             <= kill_i ? DRAIN : COLLECT;
                    end else if (kill_i) begin
                        ifill_req_valid_o <= 1'b0;
                        state             <= IDLE;
                        busy_o            <= 1'b0;
                        miss_ready_o      <= 1'b1;
                    end
                end
                COLLECT: begin
                    mask <= mask_next;
                    if (ifill_resp_valid_i && !kill_i) begin
                        line_buf[slot*BEAT_WIDTH +: BEAT_WIDTH] <= ifill_resp_data_i;
                    end
                    // A kill whose own beat completes the mask has nothing left to drain.
                    if (mask_full && kill_i) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        miss_ready_o <= 1'b1;
                    end else if (mask_full) begin
                        state        <= WRITE;
                        line_valid_o <= 1'b1;
                    end else if (kill_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mask <= mask_next;
                    if (mask_full) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        miss_ready_o <= 1'b1;
                    end
                end
                WRITE: begin
                    line_valid_o <= 1'b0;
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    miss_ready_o <= 1'b1;
                end
                default: begin
                    state             <= IDLE;
                    line_valid_o      <= 1'b0;
                    ifill_req_valid_o <= 1'b0;
                    busy_o            <= 1'b0;
                    miss_ready_o      <= 1'b1;
                end
            endcase
        end
    end

    assign ifill_req_paddr_o = paddr_q;
    assign ifill_req_way_o   = way_q;
    assign line_paddr_o      = paddr_q;
    assign line_way_o        = way_q;
    assign line_data_o       = line_buf;

endmodule

// File: tb/tb_icache_ifill_unit.sv
// Directed bench for icache_ifill_unit: default geometry via a vector table,
// plus hand sequences for drain, duplicates, async reset and alternate geometries.
module tb_icache_ifill_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance
    logic         miss_valid = 0, kill = 0, ack = 0, rv = 0;
    logic [26:0]  paddr = '0;
    logic [1:0]   way = '0, beat = '0;
    logic [63:0]  data = '0;
    logic         miss_ready, req_valid, line_valid, busy;
    logic [26:0]  req_paddr, line_paddr;
    logic [1:0]   req_way, line_way;
    logic [255:0] line_data;

    icache_ifill_unit dut (
        .clk_i(clk), .rst_i(rst),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
        .miss_paddr_i(paddr), .miss_way_i(way), .kill_i(kill),
        .ifill_req_valid_o(req_valid), .ifill_req_paddr_o(req_paddr), .ifill_req_way_o(req_way),
        .ifill_ack_i(ack), .ifill_resp_valid_i(rv), .ifill_resp_data_i(data), .ifill_resp_beat_i(beat),
        .line_valid_o(line_valid), .line_data_o(line_data), .line_paddr_o(line_paddr),
        .line_way_o(line_way), .busy_o(busy)
    );

    // 512/128, 8-way instance
    logic         m2 = 0, k2 = 0, ack2 = 0, rv2 = 0;
    logic [26:0]  p2 = '0;
    logic [2:0]   w2 = '0;
    logic [1:0]   b2 = '0;
    logic [127:0] d2 = '0;
    logic         rdy2, req2, lv2, busy2;
    logic [26:0]  rp2, lp2;
    logic [2:0]   rw2, lw2;
    logic [511:0] ld2;

    icache_ifill_unit #(.LINE_WIDTH(512), .BEAT_WIDTH(128), .N_WAY(8)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .miss_valid_i(m2), .miss_ready_o(rdy2), .miss_paddr_i(p2), .miss_way_i(w2), .kill_i(k2),
        .ifill_req_valid_o(req2), .ifill_req_paddr_o(rp2), .ifill_req_way_o(rw2),
        .ifill_ack_i(ack2), .ifill_resp_valid_i(rv2), .ifill_resp_data_i(d2), .ifill_resp_beat_i(b2),
        .line_valid_o(lv2), .line_data_o(ld2), .line_paddr_o(lp2), .line_way_o(lw2), .busy_o(busy2)
    );

    // Single-beat instance
    logic         m3 = 0, k3 = 0, ack3 = 0, rv3 = 0;
    logic [26:0]  p3 = '0;
    logic [1:0]   w3 = '0;
    logic [0:0]   b3 = '0;
    logic [255:0] d3 = '0;
    logic         rdy3, req3, lv3, busy3;
    logic [26:0]  rp3, lp3;
    logic [1:0]   rw3, lw3;
    logic [255:0] ld3;

    icache_ifill_unit #(.LINE_WIDTH(256), .BEAT_WIDTH(256), .N_WAY(4)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .miss_valid_i(m3), .miss_ready_o(rdy3), .miss_paddr_i(p3), .miss_way_i(w3), .kill_i(k3),
        .ifill_req_valid_o(req3), .ifill_req_paddr_o(rp3), .ifill_req_way_o(rw3),
        .ifill_ack_i(ack3), .ifill_resp_valid_i(rv3), .ifill_resp_data_i(d3), .ifill_resp_beat_i(b3),
        .line_valid_o(lv3), .line_data_o(ld3), .line_paddr_o(lp3), .line_way_o(lw3), .busy_o(busy3)
    );

    // flags = {line_valid, miss_ready, req_valid, busy}
    localparam logic [3:0] F_REQ  = 4'b0011;
    localparam logic [3:0] F_BUSY = 4'b0001;
    localparam logic [3:0] F_IDLE = 4'b0100;
    localparam logic [3:0] F_WR   = 4'b1001;

    typedef struct {
        logic         mv;
        logic [26:0]  paddr;
        logic [1:0]   way;
        logic         kill, ack, rv;
        logic [1:0]   beat;
        logic [63:0]  data;
        logic [3:0]   e_flags;
        logic         chk;
        logic [255:0] e_line;
        logic [26:0]  e_paddr;
        logic [1:0]   e_way;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic mv, input logic [26:0] p, input logic [1:0] w,
                                input logic k, input logic a, input logic r, input logic [1:0] b,
                                input logic [63:0] d, input logic [3:0] f);
        vec_t v;
        v.mv = mv; v.paddr = p; v.way = w; v.kill = k; v.ack = a; v.rv = r;
        v.beat = b; v.data = d; v.e_flags = f;
        v.chk = 1'b0; v.e_line = '0; v.e_paddr = '0; v.e_way = '0;
        return v;
    endfunction

    function automatic vec_t mkl(input vec_t base, input logic [255:0] l,
                                 input logic [26:0] p, input logic [1:0] w);
        vec_t v = base;
        v.chk = 1'b1; v.e_line = l; v.e_paddr = p; v.e_way = w;
        return v;
    endfunction

    function automatic vec_t idle(input logic [3:0] f);
        return mk(0, '0, '0, 0, 0, 0, '0, '0, f);
    endfunction

    function automatic vec_t bt(input logic [1:0] b, input logic [63:0] d, input logic [3:0] f);
        return mk(0, '0, '0, 0, 0, 1, b, d, f);
    endfunction

    function automatic logic [127:0] d2f(input int k);
        return {64'(32'hC0 + k), 64'(32'h50 + k)};
    endfunction

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        miss_valid = v.mv; paddr = v.paddr; way = v.way; kill = v.kill;
        ack = v.ack; rv = v.rv; beat = v.beat; data = v.data;
        @(posedge clk);
        #1;
        check({nm, ".flags"}, {line_valid, miss_ready, req_valid, busy}, v.e_flags);
        if (v.chk) begin
            check({nm, ".line"}, line_data, v.e_line);
            check({nm, ".paddr"}, line_paddr, v.e_paddr);
            check({nm, ".way"}, line_way, v.e_way);
            check({nm, ".req_paddr"}, req_paddr, v.e_paddr);
            check({nm, ".req_way"}, req_way, v.e_way);
        end
    endtask

    task automatic cyc2(input logic mv, input logic a, input logic r, input logic [1:0] b,
                        input logic [127:0] d);
        @(negedge clk);
        m2 = mv; p2 = 27'h0000077; w2 = 3'd7; k2 = 0; ack2 = a; rv2 = r; b2 = b; d2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc3(input logic mv, input logic a, input logic r, input logic [255:0] d);
        @(negedge clk);
        m3 = mv; p3 = 27'h0000088; w3 = 2'd1; k3 = 0; ack3 = a; rv3 = r; b3 = 1'b0; d3 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] line_a, line_b, line_d, line_f, single;
        line_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_b = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        line_d = {64'hD3, 64'hD2, 64'h22, 64'hD0};
        line_f = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
        single = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};

        // In-order default fill, ack three cycles after the miss
        tbl.push_back(mk(1, 27'h1234567, 2'd2, 0, 0, 0, '0, '0, F_REQ));
        tbl.push_back(idle(F_REQ));
        tbl.push_back(idle(F_REQ));
        tbl.push_back(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY));
        tbl.push_back(bt(2'd0, 64'hA0, F_BUSY));
        tbl.push_back(bt(2'd1, 64'hA1, F_BUSY));
        tbl.push_back(bt(2'd2, 64'hA2, F_BUSY));
        tbl.push_back(mkl(bt(2'd3, 64'hA3, F_WR), line_a, 27'h1234567, 2'd2));
        tbl.push_back(mkl(idle(F_IDLE), line_a, 27'h1234567, 2'd2));
        // Out-of-order beats 3,1,0,2 with gaps; a stray beat in IDLE afterwards
        tbl.push_back(mk(1, 27'h0ABCDEF, 2'd1, 0, 0, 0, '0, '0, F_REQ));
        tbl.push_back(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY));
        tbl.push_back(bt(2'd3, 64'hB3, F_BUSY));
        tbl.push_back(idle(F_BUSY));
        tbl.push_back(bt(2'd1, 64'hB1, F_BUSY));
        tbl.push_back(bt(2'd0, 64'hB0, F_BUSY));
        tbl.push_back(idle(F_BUSY));
        tbl.push_back(mkl(bt(2'd2, 64'hB2, F_WR), line_b, 27'h0ABCDEF, 2'd1));
        tbl.push_back(idle(F_IDLE));
        tbl.push_back(mkl(bt(2'd0, 64'hFF, F_IDLE), line_b, 27'h0ABCDEF, 2'd1));
        // Kill in REQ without ack, then a beat that must be ignored
        tbl.push_back(mk(1, 27'h0000011, 2'd3, 0, 0, 0, '0, '0, F_REQ));
        tbl.push_back(mk(0, '0, '0, 1, 0, 0, '0, '0, F_IDLE));
        tbl.push_back(bt(2'd0, 64'hEE, F_IDLE));
        // Kill together with ack: every beat is drained, no line write
        tbl.push_back(mk(1, 27'h0000022, 2'd0, 0, 0, 0, '0, '0, F_REQ));
        tbl.push_back(mk(0, '0, '0, 1, 1, 0, '0, '0, F_BUSY));
        tbl.push_back(bt(2'd0, 64'h1, F_BUSY));
        tbl.push_back(bt(2'd1, 64'h2, F_BUSY));
        tbl.push_back(bt(2'd2, 64'h3, F_BUSY));
        tbl.push_back(bt(2'd3, 64'h4, F_IDLE));

        // Reset state
        #12;
        check("rst.flags", {line_valid, miss_ready, req_valid, busy}, F_IDLE);
        check("rst.line", line_data, '0);
        check("rst.paddr", line_paddr, '0);
        check("rst.way", line_way, '0);
        check("rst.dut2", {lv2, rdy2, req2, busy2}, F_IDLE);
        check("rst.dut3", {lv3, rdy3, req3, busy3}, F_IDLE);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Kill in COLLECT after two beats; the beat in the kill cycle counts toward the drain
        run_vec(mk(1, 27'h0000033, 2'd1, 0, 0, 0, '0, '0, F_REQ), "kc.miss");
        run_vec(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY), "kc.ack");
        run_vec(bt(2'd0, 64'hC0, F_BUSY), "kc.b0");
        run_vec(bt(2'd1, 64'hC1, F_BUSY), "kc.b1");
        run_vec(mk(0, '0, '0, 1, 0, 1, 2'd2, 64'hC2, F_BUSY), "kc.kill_b2");
        run_vec(idle(F_BUSY), "kc.gap");
        run_vec(bt(2'd3, 64'hC3, F_IDLE), "kc.b3");

        // Duplicate beat 1: later data wins, one write; kill during the write is ignored
        run_vec(mk(1, 27'h0000044, 2'd3, 0, 0, 0, '0, '0, F_REQ), "dup.miss");
        run_vec(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY), "dup.ack");
        run_vec(bt(2'd1, 64'h11, F_BUSY), "dup.b1a");
        run_vec(bt(2'd1, 64'h22, F_BUSY), "dup.b1b");
        run_vec(bt(2'd0, 64'hD0, F_BUSY), "dup.b0");
        run_vec(bt(2'd2, 64'hD2, F_BUSY), "dup.b2");
        run_vec(mkl(bt(2'd3, 64'hD3, F_WR), line_d, 27'h0000044, 2'd3), "dup.b3");
        run_vec(mkl(mk(0, '0, '0, 1, 0, 0, '0, '0, F_IDLE), line_d, 27'h0000044, 2'd3), "dup.kill_wr");

        // Asynchronous reset mid-COLLECT, then a clean refill
        run_vec(mk(1, 27'h0000055, 2'd2, 0, 0, 0, '0, '0, F_REQ), "ar.miss");
        run_vec(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY), "ar.ack");
        run_vec(bt(2'd0, 64'hE0, F_BUSY), "ar.b0");
        run_vec(bt(2'd1, 64'hE1, F_BUSY), "ar.b1");
        @(negedge clk);
        rv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ar.flags", {line_valid, miss_ready, req_valid, busy}, F_IDLE);
        check("ar.line", line_data, '0);
        check("ar.paddr", line_paddr, '0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1, 27'h0000066, 2'd1, 0, 0, 0, '0, '0, F_REQ), "ar2.miss");
        run_vec(mk(0, '0, '0, 0, 1, 0, '0, '0, F_BUSY), "ar2.ack");
        run_vec(bt(2'd2, 64'hF2, F_BUSY), "ar2.b2");
        run_vec(bt(2'd3, 64'hF3, F_BUSY), "ar2.b3");
        run_vec(bt(2'd0, 64'hF0, F_BUSY), "ar2.b0");
        run_vec(mkl(bt(2'd1, 64'hF1, F_WR), line_f, 27'h0000066, 2'd1), "ar2.b1");
        run_vec(idle(F_IDLE), "ar2.idle");

        // 512/128 geometry, 8 ways, beats 2,0,3,1
        cyc2(1, 0, 0, '0, '0);
        check("g2.req", {req2, busy2, rdy2}, 3'b110);
        check("g2.req_paddr", rp2, 27'h0000077);
        check("g2.req_way", rw2, 3'd7);
        cyc2(0, 1, 0, '0, '0);
        cyc2(0, 0, 1, 2'd2, d2f(2));
        cyc2(0, 0, 1, 2'd0, d2f(0));
        cyc2(0, 0, 1, 2'd3, d2f(3));
        check("g2.no_early", lv2, 1'b0);
        cyc2(0, 0, 1, 2'd1, d2f(1));
        check("g2.lv", lv2, 1'b1);
        check("g2.line", ld2, {d2f(3), d2f(2), d2f(1), d2f(0)});
        check("g2.paddr", lp2, 27'h0000077);
        check("g2.way", lw2, 3'd7);
        cyc2(0, 0, 0, '0, '0);
        check("g2.after", {lv2, rdy2}, 2'b01);

        // Single-beat geometry: first beat completes the line
        cyc3(1, 0, 0, '0);
        check("g3.req", {req3, busy3, rdy3}, 3'b110);
        check("g3.req_addr", {rp3, rw3}, {27'h0000088, 2'd1});
        cyc3(0, 1, 0, '0);
        cyc3(0, 0, 1, single);
        check("g3.lv", lv3, 1'b1);
        check("g3.line", ld3, single);
        check("g3.addr", {lp3, lw3}, {27'h0000088, 2'd1});
        cyc3(0, 0, 0, '0);
        check("g3.after", {lv3, rdy3}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
